// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between requesters A and B, one access at a time
// Ports: clk, reset_n (async, active-low)
//        a_req/a_we/a_addr/a_wdata in, a_ack (1-cycle pulse)/a_rdata out -- requester A
//        b_req/b_we/b_addr/b_wdata in, b_ack (1-cycle pulse)/b_rdata out -- requester B
//        mem_address/mem_read_enable/mem_write_enable/mem_data_in out, mem_data_out in -- memory side
//        busy = access in flight, owner = port of current/last grant (0 = A, 1 = B)
module mem_port_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 16,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
    state_t            state, state_n;
    logic              last_b, last_b_n;
    logic              op_we, op_we_n;
    logic              owner_n, busy_n, a_ack_n, b_ack_n, read_en_n, write_en_n;
    logic [ADDR_W-1:0] address_n;
    logic [DATA_W-1:0] data_in_n, a_rdata_n, b_rdata_n;
    logic              win, sel_we;
    // On a tie the port not granted last wins (A always, when fixed); a lone requester always wins.
    assign win    = (a_req && b_req) ? (FIXED_PRIORITY == 0) && !last_b : b_req;
    assign sel_we = win ? b_we : a_we;
    always_comb begin
        state_n    = state;
        last_b_n   = last_b;
        op_we_n    = op_we;
        owner_n    = owner;
        address_n  = mem_address;
        data_in_n  = mem_data_in;
        read_en_n  = 1'b0;
        write_en_n = 1'b0;
        a_ack_n    = 1'b0;
        b_ack_n    = 1'b0;
        a_rdata_n  = a_rdata;
        b_rdata_n  = b_rdata;
        case (state)
            IDLE: if (a_req || b_req) begin
                state_n    = ACCESS;
                owner_n    = win;
                last_b_n   = win;
                op_we_n    = sel_we;
                address_n  = win ? b_addr : a_addr;
                data_in_n  = win ? b_wdata : a_wdata;
                read_en_n  = !sel_we;
                write_en_n = sel_we;
            end
            ACCESS: state_n = CAPTURE;
            CAPTURE: begin
                state_n   = DONE;
                a_rdata_n = (!op_we && !owner) ? mem_data_out : a_rdata;
                b_rdata_n = (!op_we && owner) ? mem_data_out : b_rdata;
                a_ack_n   = !owner;
                b_ack_n   = owner;
            end
            DONE: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            last_b           <= 1'b1;
            op_we            <= 1'b0;
            owner            <= 1'b0;
            busy             <= 1'b0;
            mem_address      <= '0;
            mem_data_in      <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            a_ack            <= 1'b0;
            b_ack            <= 1'b0;
            a_rdata          <= '0;
            b_rdata          <= '0;
        end else begin
            state            <= state_n;
            last_b           <= last_b_n;
            op_we            <= op_we_n;
            owner            <= owner_n;
            busy             <= busy_n;
            mem_address      <= address_n;
            mem_data_in      <= data_in_n;
            mem_read_enable  <= read_en_n;
            mem_write_enable <= write_en_n;
            a_ack            <= a_ack_n;
            b_ack            <= b_ack_n;
            a_rdata          <= a_rdata_n;
            b_rdata          <= b_rdata_n;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (round-robin DUT plus a fixed-priority copy)
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ack, b_ack, mem_read_enable, mem_write_enable, busy, owner;
    logic [DW-1:0] a_rdata, b_rdata, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;
    logic          fp_a_ack, fp_b_ack, fp_re, fp_we, fp_busy, fp_owner;
    logic [DW-1:0] fp_a_rdata, fp_b_rdata, fp_din, fp_mdo;
    logic [AW-1:0] fp_addr;
    always #5 clk = ~clk;
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy), .owner(owner)
    );
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(fp_a_ack), .a_rdata(fp_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(fp_b_ack), .b_rdata(fp_b_rdata),
        .mem_address(fp_addr), .mem_read_enable(fp_re), .mem_write_enable(fp_we),
        .mem_data_in(fp_din), .mem_data_out(fp_mdo), .busy(fp_busy), .owner(fp_owner)
    );
    int tests = 0;
    int fails = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 5) ? 16'h1234 : 16'((i * 40503) ^ 23130);
    endfunction
    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
    endfunction
    // Memory for the round-robin DUT: read data appears the cycle after the enable cycle.
    logic [DW-1:0] mem [1024];
    bit            mem_loaded;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else begin
            if (mem_write_enable) mem[mem_address] <= mem_data_in;
            if (mem_read_enable) mem_data_out <= mem[mem_address];
        end
    end
    // Synthetic memory for the fixed-priority copy: reads return address + 0x100.
    always @(posedge clk) if (fp_re || fp_we) fp_mdo <= fp_we ? fp_din : 16'(fp_addr) + 16'h0100;
    // Reference model: a transaction is granted on the first edge a request is seen while the
    // arbiter is free; it then occupies the memory for four edges in total.
    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            cyc;
    } txn_t;
    txn_t          mq[$];
    txn_t          aq[$];
    int            cyc = 0;
    int            cnt = 0;
    bit            last_b = 1'b1;
    bit            sh_loaded;
    logic [DW-1:0] shadow [1024];
    always @(posedge clk or negedge reset_n) begin : model
        txn_t t;
        if (!reset_n) begin
            mq.delete();
            aq.delete();
            cnt = 0;
            last_b = 1'b1;
            if (!sh_loaded) begin
                for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
                sh_loaded = 1'b1;
            end
        end else begin
            cyc++;
            if (cnt > 0) cnt--;
            else if (a_req || b_req) begin
                t.port  = (a_req && b_req) ? !last_b : b_req;
                t.we    = t.port ? b_we : a_we;
                t.addr  = t.port ? b_addr : a_addr;
                t.wdata = t.port ? b_wdata : a_wdata;
                t.rdata = shadow[t.addr];
                t.cyc   = cyc;
                if (t.we) shadow[t.addr] = t.wdata;
                last_b = t.port;
                cnt = 3;
                mq.push_back(t);
                aq.push_back(t);
            end
        end
    end
    // Monitor: pops expectations whenever the DUT drives the memory or acks a port.
    logic [DW-1:0] last_rd [2];
    always @(negedge clk) begin : monitor
        txn_t t;
        if (!reset_n) begin
            last_rd[0] = '0;
            last_rd[1] = '0;
        end else begin
            chk("busy", 32'(busy), 32'(cnt != 0));
            if (mem_read_enable || mem_write_enable) begin
                if (mq.size() == 0) chk("mem_unexpected_enable", 1, 0);
                else begin
                    t = mq.pop_front();
                    chk("mem_enables", {mem_read_enable, mem_write_enable}, t.we ? 2'b01 : 2'b10);
                    chk("mem_address", 32'(mem_address), 32'(t.addr));
                    chk("mem_data_in", 32'(mem_data_in), 32'(t.wdata));
                    chk("enable_cycle", cyc, t.cyc);
                end
            end
            if (a_ack || b_ack) begin
                if (aq.size() == 0) chk("ack_unexpected", 1, 0);
                else begin
                    t = aq.pop_front();
                    if (!t.we) last_rd[t.port] = t.rdata;
                    chk("ack_port", {a_ack, b_ack}, t.port ? 2'b01 : 2'b10);
                    chk("ack_cycle", cyc, t.cyc + 2);
                    chk("owner", 32'(owner), 32'(t.port));
                    chk("a_rdata", 32'(a_rdata), 32'(last_rd[0]));
                    chk("b_rdata", 32'(b_rdata), 32'(last_rd[1]));
                end
            end
        end
    end
    int            r_en, r_lat, r_other;
    logic          r_en_we;
    logic [AW-1:0] r_en_addr;
    logic [DW-1:0] r_en_din, r_rd;
    task automatic run_txn(input bit p, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int c0;
        r_en = 0; r_lat = -1; r_other = 0; r_rd = '0; r_en_we = 1'b0; r_en_addr = '0; r_en_din = '0;
        if (p) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
        else begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
        c0 = cyc;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (mem_read_enable || mem_write_enable) begin
                r_en++; r_en_we = mem_write_enable; r_en_addr = mem_address; r_en_din = mem_data_in;
            end
            if (p ? a_ack : b_ack) r_other = 1;
            if ((p ? b_ack : a_ack) && r_lat < 0) begin
                r_lat = cyc - c0;
                r_rd = p ? b_rdata : a_rdata;
                a_req = 1'b0;
                b_req = 1'b0;
            end
        end
    endtask
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin : stim
        int t_en, ta, tb, n_ack, fa_cnt, fb_cnt, t_drop;
        logic [3:0] ord;
        int ack_c [4];
        repeat (3) @(negedge clk);
        chk("rst_a_ack", 32'(a_ack), 0);
        chk("rst_b_ack", 32'(b_ack), 0);
        chk("rst_a_rdata", 32'(a_rdata), 0);
        chk("rst_b_rdata", 32'(b_rdata), 0);
        chk("rst_mem_en", {mem_read_enable, mem_write_enable}, 0);
        chk("rst_mem_addr_data", {mem_address, mem_data_in}, 0);
        chk("rst_busy_owner", {busy, owner}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        // Reset asserted in the middle of an A read abandons it without an ack.
        a_we = 1'b0; a_addr = 10'h005; a_req = 1'b1;
        for (int i = 0; i < 8 && !mem_read_enable; i++) @(negedge clk);
        chk("t1_enable_seen", 32'(mem_read_enable), 1);
        reset_n = 1'b0;
        a_req = 1'b0;
        #1;
        chk("t1_enables_drop", {mem_read_enable, mem_write_enable}, 0);
        chk("t1_busy_owner", {busy, owner}, 0);
        ta = 0;
        repeat (3) begin @(negedge clk); ta |= 32'(a_ack | b_ack); end
        reset_n = 1'b1;
        repeat (4) begin @(negedge clk); ta |= 32'(a_ack | b_ack); end
        chk("t1_no_ack", ta, 0);
        chk("t1_idle", 32'(busy), 0);
        // A read of a known location.
        run_txn(1'b0, 1'b0, 10'h005, 16'h0);
        chk("t2_enable_cycles", r_en, 1);
        chk("t2_enable_kind", 32'(r_en_we), 0);
        chk("t2_address", 32'(r_en_addr), 32'h005);
        chk("t2_latency", r_lat, 3);
        chk("t2_rdata", 32'(r_rd), 32'h1234);
        chk("t2_b_ack_quiet", r_other, 0);
        chk("t2_rdata_held", 32'(a_rdata), 32'h1234);
        // B write to the top address, then A reads it back.
        run_txn(1'b1, 1'b1, 10'h3FF, 16'hBEEF);
        chk("t3_enable_cycles", r_en, 1);
        chk("t3_enable_kind", 32'(r_en_we), 1);
        chk("t3_address", 32'(r_en_addr), 32'h3FF);
        chk("t3_data_in", 32'(r_en_din), 32'hBEEF);
        chk("t3_latency", r_lat, 3);
        chk("t3_a_ack_quiet", r_other, 0);
        run_txn(1'b0, 1'b0, 10'h3FF, 16'h0);
        chk("t3_readback", 32'(r_rd), 32'hBEEF);
        chk("t3_a_rdata_kept", 32'(a_rdata), 32'hBEEF);
        // B arrives while A is in its enable cycle: no preemption, B follows four cycles later.
        a_we = 1'b0; a_addr = 10'h007; a_req = 1'b1;
        for (int i = 0; i < 8 && !mem_read_enable; i++) @(negedge clk);
        t_en = cyc;
        b_we = 1'b0; b_addr = 10'h008; b_req = 1'b1;
        ta = -100; tb = -100;
        for (int i = 0; i < 16 && tb < 0; i++) begin
            @(negedge clk);
            if (a_ack) begin ta = cyc; a_req = 1'b0; end
            if (b_ack) begin tb = cyc; b_req = 1'b0; end
        end
        chk("t6_a_latency", ta - t_en, 2);
        chk("t6_b_gap", tb - ta, 4);
        // Random traffic from both requesters against the scoreboard.
        for (int n = 0; n < 1600; n++) begin
            @(negedge clk);
            if (a_ack) a_req = 1'b0;
            if (b_ack) b_req = 1'b0;
            if (n < 1500 && !a_req && $urandom_range(0, 2) == 0) begin
                a_we = 1'($urandom_range(0, 1)); a_addr = rand_addr(); a_wdata = 16'($urandom); a_req = 1'b1;
            end
            if (n < 1500 && !b_req && $urandom_range(0, 2) == 0) begin
                b_we = 1'($urandom_range(0, 1)); b_addr = rand_addr(); b_wdata = 16'($urandom); b_req = 1'b1;
            end
        end
        chk("drain_idle", {busy, a_req, b_req}, 0);
        chk("drain_queues", mq.size() + aq.size(), 0);
        // Both requesters held from reset: round-robin alternates, fixed priority serves only A.
        reset_n = 1'b0;
        a_we = 1'b0; a_addr = 10'h011; a_req = 1'b1;
        b_we = 1'b0; b_addr = 10'h022; b_req = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_ack = 0; fa_cnt = 0; fb_cnt = 0; ord = '0;
        for (int i = 0; i < 40 && n_ack < 4; i++) begin
            @(negedge clk);
            if (fp_a_ack) begin fa_cnt++; chk("t5_fp_a_rdata", 32'(fp_a_rdata), 32'h0111); end
            if (fp_b_ack) fb_cnt++;
            if (a_ack || b_ack) begin
                ord[3 - n_ack] = b_ack;
                ack_c[n_ack] = cyc;
                n_ack++;
            end
        end
        chk("t4_order", 32'(ord), 32'b0101);
        chk("t4_gap0", ack_c[1] - ack_c[0], 4);
        chk("t4_gap1", ack_c[2] - ack_c[1], 4);
        chk("t4_gap2", ack_c[3] - ack_c[2], 4);
        chk("t5_fp_a_count", fa_cnt, 4);
        chk("t5_fp_b_count", fb_cnt, 0);
        chk("t5_fp_busy", 32'(fp_busy), 1);
        a_req = 1'b0;
        t_drop = cyc;
        tb = -100;
        for (int i = 0; i < 12 && tb < 0; i++) begin
            @(negedge clk);
            if (fp_a_ack) fa_cnt++;
            if (fp_b_ack) begin
                tb = cyc;
                b_req = 1'b0;
                chk("t5_fp_owner", 32'(fp_owner), 1);
                chk("t5_fp_b_rdata", 32'(fp_b_rdata), 32'h0122);
            end
        end
        chk("t5_b_after_drop", tb - t_drop, 4);
        chk("t5_fp_a_stopped", fa_cnt, 4);
        repeat (8) @(negedge clk);
        chk("final_queues", mq.size() + aq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
